async_fifo_lvl: RTL and testbench
=================================

ASYNC_FIFO_LVL -- requirements
Module: async_fifo_lvl

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, meaning width of each stored word.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 4, meaning log2 of depth (DEPTH = 2**ADDR_WIDTH = 16); legal range 2..12.
REQ-003 SHALL provide parameter SYNC_STAGES, default 2, meaning flop count of each Gray-pointer synchroniser; legal range 2..4.
REQ-004 SHALL provide parameter AFULL_TH, default DEPTH-2, meaning write-side level at or above which walmost_full asserts.
REQ-005 SHALL provide parameter AEMPTY_TH, default 2, meaning read-side level at or below which ralmost_empty asserts.
REQ-006 wclk  in  1  write-domain clock.
REQ-007 rclk  in  1  read-domain clock, asynchronous to wclk.
REQ-008 rst_n  in  1  reset, asynchronous, active-low, applied to both domains.
REQ-009 wr_en  in  1  write request, wclk domain.
REQ-010 wdata  in  DATA_WIDTH  write data, sampled with wr_en.
REQ-011 wfull  out  1  FIFO full, wclk domain, registered.
REQ-012 walmost_full  out  1  wlevel >= AFULL_TH, registered.
REQ-013 wlevel  out  ADDR_WIDTH+1  write-side occupancy 0..DEPTH, registered.
REQ-014 woverflow  out  1  sticky: write attempted while full.
REQ-015 rd_en  in  1  read request, rclk domain.
REQ-016 rdata  out  DATA_WIDTH  read data, registered.
REQ-017 rvalid  out  1  rdata holds a word popped on the previous rclk edge.
REQ-018 rempty  out  1  FIFO empty, rclk domain, registered.
REQ-019 ralmost_empty  out  1  rlevel <= AEMPTY_TH, registered.
REQ-020 rlevel  out  ADDR_WIDTH+1  read-side occupancy 0..DEPTH, registered.
REQ-021 runderflow  out  1  sticky: read attempted while empty.

Function
REQ-022 Pointers SHALL be ADDR_WIDTH+1 bits (binary + registered Gray copy); MSB is wrap bit; memory indexed by low ADDR_WIDTH bits; increments wrap modulo 2**(ADDR_WIDTH+1).
REQ-023 Write accepted iff wr_en=1 and wfull=0 at wclk edge: mem[wptr] <= wdata, wptr += 1; otherwise memory and wptr unchanged.
REQ-024 Read accepted iff rd_en=1 and rempty=0 at rclk edge: rdata <= mem[rptr], rptr += 1, rvalid <= 1; otherwise rvalid <= 0 and rdata holds last value.
REQ-025 Only Gray pointers SHALL cross domains, each through SYNC_STAGES flops; no binary or multi-bit non-Gray signal crosses.
REQ-026 wfull SHALL be registered from next-state wptr Gray == synchronised rptr Gray with top two bits inverted; asserts on the same edge that accepts the DEPTH-th outstanding write.
REQ-027 rempty SHALL be registered from next-state rptr Gray == synchronised wptr Gray; asserts on the edge that accepts the last read.
REQ-028 wlevel = next wptr − binary(synchronised rptr), rlevel = binary(synchronised wptr) − next rptr, both modulo 2**(ADDR_WIDTH+1); values are conservative (never under-report on write side, never over-report on read side).
REQ-029 Write to empty FIFO: rempty SHALL deassert no earlier than SYNC_STAGES+1 and no later than SYNC_STAGES+2 rclk edges after the write edge; symmetric bound for wfull release after a read.
REQ-030 Simultaneous accepted write and read SHALL both complete; flags re-evaluate from both next pointers.
REQ-031 woverflow SET on wr_en=1 with wfull=1; runderflow SET on rd_en=1 with rempty=1; both clear only on reset; rejected accesses leave pointers and memory unchanged.
REQ-032 Full-depth operation: all DEPTH entries usable (no lost slot).

Reset
REQ-033 rst_n low SHALL asynchronously clear all pointers, synchroniser flops, wlevel, rlevel, rdata, rvalid, woverflow, runderflow, walmost_full to 0 and set rempty=1, ralmost_empty=1, wfull=0.
REQ-034 Reset mid-operation SHALL discard all stored words; after release first write lands at address 0 and first read returns it.
REQ-035 rst_n deassertion is synchronised externally per domain; memory contents need no reset.

Verification
REQ-036 Reset then write 0x00..0x0F (wclk 100 MHz, rclk 37 MHz) -> wfull=1 after 16th accepted write, wlevel=16, 17th write sets woverflow=1 and is dropped.
REQ-037 Drain full FIFO -> rdata sequence 0x00..0x0F with rvalid, rempty=1 after 16th read, extra rd_en sets runderflow=1, rdata holds 0x0F.
REQ-038 Single write to empty FIFO -> rempty deasserts 3..4 rclk edges later (SYNC_STAGES=2), rlevel=1, ralmost_empty=1.
REQ-039 Continuous write/read for 1000 words with random rd_en/wr_en gaps, both clock ratios (fast-write and fast-read) -> in-order, no loss/duplication, pointers wrap ≥ 60 times, no flags sticky.
REQ-040 Fill to 14 entries -> walmost_full=1 at wlevel=14; drain to 2 -> ralmost_empty=1 at rlevel=2.
REQ-041 Assert rst_n low with 9 words stored -> all outputs at REQ-033 values immediately; refill with 0xA5 -> read returns 0xA5.

Source files
------------

// File: rtl/async_fifo_lvl.sv
`timescale 1ns/1ps
// async_fifo_lvl
// Dual-clock FIFO with Gray-coded pointer crossing and occupancy levels on
// both sides. Only registered Gray pointers cross between domains.
//
// Ports
//   wclk, rclk        write / read clocks (mutually asynchronous)
//   rst_n             asynchronous active-low reset for both domains
//   wr_en, wdata      write request and data (wclk)
//   wfull, walmost_full, wlevel, woverflow   write-side status (wclk)
//   rd_en             read request (rclk)
//   rdata, rvalid     registered read data, valid for one cycle per pop
//   rempty, ralmost_empty, rlevel, runderflow read-side status (rclk)
module async_fifo_lvl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_TH    = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_TH   = 2
) (
  input  logic                  wclk,
  input  logic                  rclk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  woverflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH:0]   rlevel,
  output logic                  runderflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_LV  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_LV = PW'(AEMPTY_TH);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------- write domain ----------------
  logic [PW-1:0] wbin, wgray, wbin_next, wgray_next, wq_rgray, wlevel_next;
  logic [SYNC_STAGES-1:0][PW-1:0] wsync;
  logic wr_ok, wfull_next;

  // rgray from the read domain, declared here so wsync can sample it
  logic [PW-1:0] rgray;

  assign wr_ok       = wr_en & ~wfull;
  assign wbin_next   = wbin + PW'(wr_ok);
  assign wgray_next  = (wbin_next >> 1) ^ wbin_next;
  assign wq_rgray    = wsync[SYNC_STAGES-1];
  // Full when the write pointer is exactly one lap ahead of the read pointer:
  // in Gray code that means the top two bits differ and the rest match.
  assign wfull_next  = (wgray_next == {~wq_rgray[PW-1:PW-2], wq_rgray[PW-3:0]});
  assign wlevel_next = wbin_next - gray2bin(wq_rgray);

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      wbin         <= '0;
      wgray        <= '0;
      wsync        <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wgray        <= wgray_next;
      wsync        <= {wsync[SYNC_STAGES-2:0], rgray};
      wfull        <= wfull_next;
      walmost_full <= (wlevel_next >= AFULL_LV);
      wlevel       <= wlevel_next;
      if (wr_en && wfull) woverflow <= 1'b1;
    end
  end

  always_ff @(posedge wclk) begin
    if (wr_ok) mem[wbin[ADDR_WIDTH-1:0]] <= wdata;
  end

  // ---------------- read domain ----------------
  logic [PW-1:0] rbin, rbin_next, rgray_next, rq_wgray, rlevel_next;
  logic [SYNC_STAGES-1:0][PW-1:0] rsync;
  logic rd_ok, rempty_next;

  assign rd_ok       = rd_en & ~rempty;
  assign rbin_next   = rbin + PW'(rd_ok);
  assign rgray_next  = (rbin_next >> 1) ^ rbin_next;
  assign rq_wgray    = rsync[SYNC_STAGES-1];
  assign rempty_next = (rgray_next == rq_wgray);
  assign rlevel_next = gray2bin(rq_wgray) - rbin_next;

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      rbin          <= '0;
      rgray         <= '0;
      rsync         <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
      runderflow    <= 1'b0;
      rvalid        <= 1'b0;
      rdata         <= '0;
    end else begin
      rbin          <= rbin_next;
      rgray         <= rgray_next;
      rsync         <= {rsync[SYNC_STAGES-2:0], wgray};
      rempty        <= rempty_next;
      ralmost_empty <= (rlevel_next <= AEMPTY_LV);
      rlevel        <= rlevel_next;
      rvalid        <= rd_ok;
      if (rd_en && rempty) runderflow <= 1'b1;
      // The slot at rbin is only readable once the synchronised write
      // pointer shows it written, so it is stable in wclk terms here.
      if (rd_ok) rdata <= mem[rbin[ADDR_WIDTH-1:0]];
    end
  end

endmodule

// File: tb/tb_async_fifo_lvl.sv
`timescale 1ns/1ps
module tb_async_fifo_lvl;

  logic        wclk = 1'b0;
  logic        rclk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wdata;
  logic        wfull, walmost_full, woverflow;
  logic [4:0]  wlevel;
  logic        rd_en;
  logic [31:0] rdata;
  logic        rvalid, rempty, ralmost_empty, runderflow;
  logic [4:0]  rlevel;

  real wh = 5.0;
  real rh = 13.5;

  int total = 0;
  int bad   = 0;

  always #(wh) wclk = ~wclk;
  always #(rh) rclk = ~rclk;

  async_fifo_lvl dut (
    .wclk(wclk), .rclk(rclk), .rst_n(rst_n),
    .wr_en(wr_en), .wdata(wdata),
    .wfull(wfull), .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow),
    .rd_en(rd_en), .rdata(rdata), .rvalid(rvalid), .rempty(rempty),
    .ralmost_empty(ralmost_empty), .rlevel(rlevel), .runderflow(runderflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wfull"}, wfull, 0);
    chk({tag, "_wafull"}, walmost_full, 0);
    chk({tag, "_wlevel"}, wlevel, 0);
    chk({tag, "_wovf"}, woverflow, 0);
    chk({tag, "_rempty"}, rempty, 1);
    chk({tag, "_raempty"}, ralmost_empty, 1);
    chk({tag, "_rlevel"}, rlevel, 0);
    chk({tag, "_runf"}, runderflow, 0);
    chk({tag, "_rvalid"}, rvalid, 0);
    chk({tag, "_rdata"}, rdata, 0);
  endtask

  task automatic wr(input logic [31:0] d);
    @(negedge wclk);
    wr_en = 1'b1;
    wdata = d;
    @(posedge wclk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic rd();
    @(negedge rclk);
    rd_en = 1'b1;
    @(posedge rclk);
    #1;
    rd_en = 1'b0;
  endtask

  // counts rclk edges until rempty drops; 99 means it never did
  task automatic wait_not_empty(output int n);
    n = 99;
    for (int e = 1; e <= 20; e++) begin
      @(posedge rclk);
      #1;
      if (!rempty) begin
        n = e;
        break;
      end
    end
  endtask

  task automatic run_stream(input string tag);
    int sent, got;
    logic exp_v;
    sent = 0;
    got  = 0;
    fork
      begin
        for (int c = 0; c < 30000 && sent < 1000; c++) begin
          @(negedge wclk);
          if (!wfull && $urandom_range(0, 3) != 0) begin
            wr_en = 1'b1;
            wdata = 32'h1000 + sent;
            sent++;
          end else begin
            wr_en = 1'b0;
          end
        end
        @(negedge wclk);
        wr_en = 1'b0;
      end
      begin
        for (int c = 0; c < 30000 && got < 1000; c++) begin
          @(negedge rclk);
          rd_en = !rempty && ($urandom_range(0, 3) != 0);
          exp_v = rd_en;
          @(posedge rclk);
          #1;
          chk({tag, "_rvalid"}, rvalid, exp_v);
          if (rvalid) begin
            chk({tag, "_data"}, rdata, 32'h1000 + got);
            got++;
          end
        end
        rd_en = 1'b0;
      end
    join
    chk({tag, "_count"}, got, 1000);
    repeat (10) @(posedge wclk);
    repeat (10) @(posedge rclk);
    #1;
    chk({tag, "_wovf"}, woverflow, 0);
    chk({tag, "_runf"}, runderflow, 0);
    chk({tag, "_rempty"}, rempty, 1);
    chk({tag, "_wlevel"}, wlevel, 0);
    chk({tag, "_wfull"}, wfull, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wdata = '0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset("por");
    #20;
    @(negedge wclk);
    rst_n = 1'b1;

    // single write into empty FIFO and crossing latency
    wr(32'h00);
    wait_not_empty(n);
    chk("lat_lo", n >= 3, 1);
    chk("lat_hi", n <= 4, 1);
    chk("lat_rlevel", rlevel, 1);
    chk("lat_raempty", ralmost_empty, 1);

    // fill to full
    for (int k = 2; k <= 16; k++) begin
      wr(k - 1);
      if (k == 13) chk("fill13_wafull", walmost_full, 0);
      if (k == 14) begin
        chk("fill14_wlevel", wlevel, 14);
        chk("fill14_wafull", walmost_full, 1);
      end
      if (k == 15) chk("fill15_wfull", wfull, 0);
    end
    chk("full_wfull", wfull, 1);
    chk("full_wlevel", wlevel, 16);
    chk("full_wovf_pre", woverflow, 0);
    wr(32'hFF);
    chk("ovf_wovf", woverflow, 1);
    chk("ovf_wlevel", wlevel, 16);
    chk("ovf_wfull", wfull, 1);
    repeat (6) @(posedge rclk);
    #1;
    chk("full_rlevel", rlevel, 16);
    chk("full_raempty", ralmost_empty, 0);

    // drain
    for (int k = 1; k <= 16; k++) begin
      rd();
      chk("drain_data", rdata, k - 1);
      chk("drain_valid", rvalid, 1);
      if (k == 13) chk("drain13_raempty", ralmost_empty, 0);
      if (k == 14) begin
        chk("drain14_rlevel", rlevel, 2);
        chk("drain14_raempty", ralmost_empty, 1);
      end
      if (k == 15) chk("drain15_rempty", rempty, 0);
    end
    chk("drained_rempty", rempty, 1);
    chk("drained_rlevel", rlevel, 0);
    chk("drained_runf_pre", runderflow, 0);
    rd();
    chk("unf_runf", runderflow, 1);
    chk("unf_rvalid", rvalid, 0);
    chk("unf_rdata", rdata, 32'h0F);
    repeat (10) @(posedge wclk);
    #1;
    chk("release_wfull", wfull, 0);
    chk("release_wlevel", wlevel, 0);
    chk("sticky_wovf", woverflow, 1);

    // reset with words stored
    for (int k = 0; k < 9; k++) wr(32'h10 + k);
    chk("nine_wlevel", wlevel, 9);
    repeat (6) @(posedge rclk);
    @(negedge wclk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("mid");
    #20;
    @(negedge wclk);
    rst_n = 1'b1;
    wr(32'hA5);
    chk("refill_wlevel", wlevel, 1);
    wait_not_empty(n);
    chk("refill_seen", n <= 4, 1);
    rd();
    chk("refill_data", rdata, 32'hA5);
    chk("refill_valid", rvalid, 1);
    chk("refill_rempty", rempty, 1);

    // streaming, fast write clock
    @(negedge wclk);
    rst_n = 1'b0;
    #30;
    rst_n = 1'b1;
    run_stream("fastw");

    // streaming, fast read clock
    rst_n = 1'b0;
    wh = 13.5;
    rh = 5.0;
    #60;
    rst_n = 1'b1;
    run_stream("fastr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
